neuron_lif_param: RTL and testbench

// - Parametrised leaky integrate-and-fire neuron tile. Successor of the fixed 3-dendrite, 3-bit-weight neuron.
// - Adds N dendrites with signed (inhibitory-capable) weights, a configurable threshold, a refractory period,
//   a saturating membrane and edge-detected leak from the shared decay bus.
// - Configured over the daisy-chained bitstream (bs_in -> bs_out). Instantiated in arrays inside the brain top.

---
 rtl/neuron_lif_param.sv | 131 +++++++++++++
 tb/tb_neuron_lif_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_lif_param.sv
// neuron_lif_param: parametrised leaky integrate-and-fire neuron tile.
//   N_DEND dendrites with signed weights, a configurable threshold and refractory period,
//   a saturating unsigned membrane, and a leak (U >> 1) on each rising edge of the
//   selected decay bus line. Configured over a daisy-chained shift register.
// Ports:
//   clk      - clock, all state on posedge
//   nn_reset - asynchronous active-high reset
//   conf_en  - 1 = shift config bitstream, 0 = run
//   bs_in    - config bitstream in
//   bs_out   - config bitstream out (top bit of the config register)
//   dend     - dendritic spike inputs
//   dBus     - shared decay clock bus
//   axon     - registered one-cycle spike output
//   u_out    - membrane value (debug)
module neuron_lif_param #(
    parameter int unsigned N_DEND = 3,
    parameter int unsigned W_BITS = 4,
    parameter int unsigned U_BITS = 8,
    parameter int unsigned DBUS_W = 8,
    parameter int unsigned REF_W  = 3
) (
    input  logic              clk,
    input  logic              nn_reset,
    input  logic              conf_en,
    input  logic              bs_in,
    output logic              bs_out,
    input  logic [N_DEND-1:0] dend,
    input  logic [DBUS_W-1:0] dBus,
    output logic              axon,
    output logic [U_BITS-1:0] u_out
);
    localparam int unsigned SEL_W   = $clog2(DBUS_W);
    localparam int unsigned CFG_LEN = N_DEND * W_BITS + SEL_W + REF_W + U_BITS;
    localparam int unsigned SUM_W   = W_BITS + $clog2(N_DEND) + 1;
    // Wide enough for UMAX plus the most positive or negative dendritic sum.
    localparam int unsigned ACC_W   = U_BITS + SUM_W + 1;
    localparam int unsigned TSEL_LO = N_DEND * W_BITS;
    localparam int unsigned REF_LO  = TSEL_LO + SEL_W;
    localparam int unsigned THR_LO  = REF_LO + REF_W;

    logic [CFG_LEN-1:0] cfg_q, cfg_d;
    logic [U_BITS-1:0]  u_q, u_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic               axon_q, axon_d;
    logic               dbus_q, dbus_d;

    logic [SEL_W-1:0]   tsel;
    logic [REF_W-1:0]   ref_val;
    logic [U_BITS-1:0]  thr;
    logic               dbus_sel;
    logic               leak;
    logic [U_BITS-1:0]  u_l;
    logic [W_BITS-1:0]  w_i;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   acc;
    logic [U_BITS-1:0]  nxt;

    assign tsel     = cfg_q[TSEL_LO +: SEL_W];
    assign ref_val  = cfg_q[REF_LO +: REF_W];
    assign thr      = cfg_q[THR_LO +: U_BITS];
    assign dbus_sel = dBus[tsel];

    assign bs_out = cfg_q[CFG_LEN-1];
    assign axon   = axon_q;
    assign u_out  = u_q;

    // Leak only on a rising edge of the selected decay line.
    assign leak = dbus_sel & ~dbus_q;
    assign u_l  = leak ? (u_q >> 1) : u_q;

    // Signed sum of the weights of the active dendrites.
    always_comb begin
        sum = '0;
        w_i = '0;
        for (int i = 0; i < N_DEND; i++) begin
            w_i = cfg_q[W_BITS*i +: W_BITS];
            if (dend[i]) begin
                sum = sum + {{(SUM_W-W_BITS){w_i[W_BITS-1]}}, w_i};
            end
        end
    end

    // Two's complement add in a never-wrapping width, then clamp to 0..UMAX.
    always_comb begin
        acc = {{(ACC_W-U_BITS){1'b0}}, u_l} + {{(ACC_W-SUM_W){sum[SUM_W-1]}}, sum};
        if (acc[ACC_W-1]) begin
            nxt = '0;
        end else if (acc[ACC_W-2:U_BITS] != '0) begin
            nxt = '1;
        end else begin
            nxt = acc[U_BITS-1:0];
        end
    end

    always_comb begin
        cfg_d     = cfg_q;
        u_d       = u_q;
        ref_cnt_d = ref_cnt_q;
        axon_d    = 1'b0;
        dbus_d    = dbus_sel;
        if (conf_en) begin
            cfg_d = {cfg_q[CFG_LEN-2:0], bs_in};
        end else if (ref_cnt_q != '0) begin
            u_d       = u_l;
            ref_cnt_d = ref_cnt_q - REF_W'(1);
        end else if ((thr != '0) && (nxt >= thr)) begin
            axon_d    = 1'b1;
            u_d       = '0;
            ref_cnt_d = ref_val;
        end else begin
            u_d = nxt;
        end
    end

    always_ff @(posedge clk or posedge nn_reset) begin
        if (nn_reset) begin
            cfg_q     <= '0;
            u_q       <= '0;
            ref_cnt_q <= '0;
            axon_q    <= 1'b0;
            dbus_q    <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            u_q       <= u_d;
            ref_cnt_q <= ref_cnt_d;
            axon_q    <= axon_d;
            dbus_q    <= dbus_d;
        end
    end

endmodule

// File: tb/tb_neuron_lif_param.sv
// Self-checking bench for neuron_lif_param at default parameters: directed scenarios
// plus randomized configurations and run traffic against a behavioural model.
module tb_neuron_lif_param;
    localparam int CL = 26;

    logic       clk = 1'b0;
    logic       nn_reset = 1'b1;
    logic       conf_en = 1'b0;
    logic       bs_in = 1'b0;
    logic       bs_out;
    logic [2:0] dend = '0;
    logic [7:0] dbus = '0;
    logic       axon;
    logic [7:0] u_out;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit hist[$];     // last CL bits shifted in, oldest first (oldest = cfg MSB)
    int m_u, m_ref, m_ax, m_dq;

    neuron_lif_param dut (
        .clk     (clk),
        .nn_reset(nn_reset),
        .conf_en (conf_en),
        .bs_in   (bs_in),
        .bs_out  (bs_out),
        .dend    (dend),
        .dBus    (dbus),
        .axon    (axon),
        .u_out   (u_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int field(input int lo, input int w);
        int v = 0;
        for (int b = 0; b < w; b++) v = v | (int'(hist[CL-1-(lo+b)]) << b);
        return v;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < CL; i++) hist.push_back(1'b0);
        m_u = 0; m_ref = 0; m_ax = 0; m_dq = 0;
    endfunction

    function automatic void model_edge(input bit c, input bit b, input bit [2:0] d,
                                       input bit [7:0] db);
        int tsel = field(12, 3);
        int rf   = field(15, 3);
        int thr  = field(18, 8);
        int sel  = int'(db[tsel]);
        if (c) begin
            hist.push_back(b);
            void'(hist.pop_front());
            m_ax = 0;
            m_dq = sel;
        end else begin
            int ul, sum, nx, w;
            ul = (sel == 1 && m_dq == 0) ? m_u / 2 : m_u;
            m_dq = sel;
            if (m_ref != 0) begin
                m_u = ul; m_ref = m_ref - 1; m_ax = 0;
            end else begin
                sum = 0;
                for (int i = 0; i < 3; i++) begin
                    if (d[i]) begin
                        w = field(4*i, 4);
                        if (w >= 8) w = w - 16;
                        sum = sum + w;
                    end
                end
                nx = ul + sum;
                if (nx < 0) nx = 0;
                if (nx > 255) nx = 255;
                if (thr != 0 && nx >= thr) begin
                    m_ax = 1; m_u = 0; m_ref = rf;
                end else begin
                    m_ax = 0; m_u = nx;
                end
            end
        end
    endfunction

    // One clock: drive at negedge, update model at posedge, compare 1 time unit later.
    task automatic step(input logic c, input logic b, input logic [2:0] d, input logic [7:0] db);
        @(negedge clk);
        conf_en = c; bs_in = b; dend = d; dbus = db;
        @(posedge clk);
        model_edge(c, b, d, db);
        #1;
        check("u", int'(u_out), m_u);
        check("axon", int'(axon), m_ax);
        check("bs_out", int'(bs_out), int'(hist[0]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        nn_reset = 1'b1;
        model_reset();
        @(negedge clk);
        nn_reset = 1'b0;
    endtask

    task automatic load_cfg(input int w0, input int w1, input int w2, input int ts,
                            input int rf, input int thr, input bit rnd_bus);
        logic [25:0] v;
        v = {thr[7:0], rf[2:0], ts[2:0], w2[3:0], w1[3:0], w0[3:0]};
        for (int i = CL - 1; i >= 0; i--) begin
            step(1'b1, v[i], 3'($urandom), rnd_bus ? 8'($urandom) : 8'h00);
        end
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_u", int'(u_out), 0);
        check("rst_axon", int'(axon), 0);
        check("rst_bs_out", int'(bs_out), 0);
        do_reset();

        // Shift 52 random bits: bs_out replays the first 26, U and axon stay 0.
        for (int i = 0; i < 2 * CL; i++) step(1'b1, 1'($urandom), 3'b111, 8'($urandom));

        // Integrate to threshold, fire, restart.
        do_reset();
        load_cfg(3, 0, 0, 0, 0, 10, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b001, 8'h00);
        check("t2_u9", int'(u_out), 9);
        step(1'b0, 1'b0, 3'b001, 8'h00);
        check("t2_fire", int'(axon), 1);
        check("t2_u0", int'(u_out), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b001, 8'h00);

        // Asynchronous reset mid-run with U=9.
        @(negedge clk);
        #2 nn_reset = 1'b1;
        #1;
        check("async_u", int'(u_out), 0);
        check("async_axon", int'(axon), 0);
        check("async_bs_out", int'(bs_out), 0);
        model_reset();
        @(negedge clk);
        nn_reset = 1'b0;

        // Inhibitory weight clamps at zero.
        load_cfg(6, -4, 0, 0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 3'b001, 8'h00);
        step(1'b0, 1'b0, 3'b010, 8'h00);
        check("t3_u2", int'(u_out), 2);
        step(1'b0, 1'b0, 3'b010, 8'h00);
        check("t3_u0", int'(u_out), 0);

        // Saturation at UMAX with threshold disabled.
        do_reset();
        load_cfg(7, 7, 7, 0, 0, 0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 3'b111, 8'h00);
        check("t4_sat", int'(u_out), 255);

        // Leak only on rising edges of dBus[2].
        step(1'b1, 1'b0, 3'b000, 8'h00);  // freeze check while shifting one bit
        do_reset();
        load_cfg(5, 0, 0, 2, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'b001, 8'h00);
        check("t5_u20", int'(u_out), 20);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b000, 8'h04);
        check("t5_u10", int'(u_out), 10);
        step(1'b0, 1'b0, 3'b000, 8'h00);
        step(1'b0, 1'b0, 3'b000, 8'h04);
        check("t5_u5", int'(u_out), 5);

        // Refractory period.
        do_reset();
        load_cfg(3, 0, 0, 0, 3, 3, 1'b0);
        step(1'b0, 1'b0, 3'b001, 8'h00);
        check("t6_fire1", int'(axon), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b001, 8'h00);
        check("t6_ref_u", int'(u_out), 0);
        step(1'b0, 1'b0, 3'b001, 8'h00);
        check("t6_fire2", int'(axon), 1);

        // Randomized configurations and traffic, with occasional mid-run config shifts.
        for (int k = 0; k < 25; k++) begin
            int thr;
            if (k % 5 == 0) do_reset();
            case ($urandom_range(0, 3))
                0: thr = 0;
                1: thr = $urandom_range(1, 20);
                2: thr = $urandom_range(1, 80);
                default: thr = $urandom_range(1, 255);
            endcase
            load_cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 7), $urandom_range(0, 7), thr, 1'b1);
            for (int i = 0; i < 40; i++) begin
                step(($urandom_range(0, 15) == 0), 1'($urandom), 3'($urandom),
                     8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
